// File: rtl/div_unit.sv
// div_unit: iterative 32-bit divider for DIV/DIVU/REM/REMU (restoring, one bit per cycle).
// Latency: done is high in the cycle after the 33rd edge following accept; with DIV_EARLY_OUT_EN
// divide-by-zero and signed overflow go straight to DONE. Backpressure: ready only in IDLE, busy stalls.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // architectural state
  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             last_q, last_d;      // all 32 iterations done, next CALC edge finalizes
  logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder (always < divisor, so fits WIDTH)
  logic [WIDTH-1:0] quo_q, quo_d;        // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;      // divisor magnitude
  logic [WIDTH-1:0] a_q, a_d;            // raw dividend, needed for the divide-by-zero remainder
  logic             rem_op_q, rem_op_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;

  // request decode, evaluated on the raw inputs at accept time
  logic             accept;
  logic             in_signed;
  logic             in_rem;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             in_div0;
  logic             in_ovf;

  // one restoring iteration
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;

  // flush wins over start so a killed instruction never starts a divide
  assign accept    = (state_q == S_IDLE) && start && !flush;
  // 100 DIV, 110 REM signed; 101 DIVU, 111 REMU unsigned; 0xx behaves as DIV
  assign in_signed = ~funct3[2] | ~funct3[0];
  assign in_rem    = funct3[2] & funct3[1];
  assign a_neg     = in_signed & a[WIDTH-1];
  assign b_neg     = in_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign in_div0   = (b == '0);
  assign in_ovf    = in_signed && (a == INT_MIN) && (b == '1);

  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign diff      = rem_sh - {1'b0, dvsr_q};
  assign ge        = ~diff[WIDTH];

  // final value: special cases override the magnitude result, then sign fix-up
  function automatic logic [WIDTH-1:0] fix_result(
    input logic             is_rem,
    input logic             is_div0,
    input logic             is_ovf,
    input logic             qneg,
    input logic             rneg,
    input logic [WIDTH-1:0] raw_a,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] rem
  );
    logic [WIDTH-1:0] r;
    if (is_div0) begin
      r = is_rem ? raw_a : '1;
    end else if (is_ovf) begin
      r = is_rem ? '0 : INT_MIN;
    end else if (is_rem) begin
      r = rneg ? -rem : rem;
    end else begin
      r = qneg ? -quo : quo;
    end
    return r;
  endfunction

  // next-state, datapath and result update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    a_d      = a_q;
    rem_op_d = rem_op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          last_d   = 1'b0;
          rem_d    = '0;
          quo_d    = a_mag;
          dvsr_d   = b_mag;
          a_d      = a;
          rem_op_d = in_rem;
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          div0_d   = in_div0;
          ovf_d    = in_ovf;
`ifdef DIV_EARLY_OUT_EN
          if (in_div0 || in_ovf) begin
            state_d  = S_DONE;
            result_d = fix_result(in_rem, in_div0, in_ovf, 1'b0, 1'b0, a, '0, '0);
          end else begin
            state_d  = S_CALC;
          end
`else
          state_d  = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (last_q) begin
          state_d  = S_DONE;
          result_d = fix_result(rem_op_q, div0_q, ovf_q, qneg_q, rneg_q, a_q, quo_q, rem_q);
        end else begin
          rem_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge};
          // counter saturates at 31; last_q marks the extra finalize cycle
          if (cnt_q == 5'd31) begin
            last_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      a_q      <= '0;
      rem_op_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      a_q      <= a_d;
      rem_op_q <= rem_op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_CALC) || (state_q == S_DONE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
